// File: rtl/stim_pkg.sv
// Shared state encoding and width helper for the stimulus sequencer slice.
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FINISH
  } state_t;

  // Ceiling log2 with a minimum of 1, so single-valued fields still get a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter that paces the sequencer; zero flags the increment slot.
module period_timer
  import stim_pkg::*;
#(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic zero
);

  localparam int unsigned W = clog2(PERIOD);
  localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stim_sequencer.sv
// Round-robin counter channels advanced every PERIOD cycles for REPEATS rounds,
// with a start/busy/done handshake and a pausable period timer.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int unsigned NCHAN   = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PERIOD  = 10,
  parameter int unsigned REPEATS = 5,
  parameter int unsigned STEP    = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  hold,
  output logic [NCHAN*WIDTH-1:0]                chan_data,
  output logic                                  upd_valid,
  output logic [clog2(NCHAN)-1:0]               upd_chan,
  output logic [clog2(NCHAN*REPEATS+1)-1:0]     step_count,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned IDX_W = clog2(NCHAN);
  localparam int unsigned CNT_W = clog2(NCHAN * REPEATS + 1);
  localparam int unsigned RND_W = clog2(REPEATS);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [RND_W-1:0]   round;
  logic               fire;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_zero;

  always_comb begin
    fire     = (state == WAIT) && !hold && tmr_zero;
    tmr_load = ((state == IDLE) && start) || fire;
    tmr_en   = (state == WAIT) && !hold;
  end

  period_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .enable(tmr_en),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      chan_data  <= '0;
      idx        <= '0;
      round      <= '0;
      upd_valid  <= 1'b0;
      upd_chan   <= '0;
      step_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            chan_data  <= '0;
            idx        <= '0;
            round      <= '0;
            step_count <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (fire) begin
            // Constant-index loop keeps the channel select free of variable part-selects.
            for (int unsigned i = 0; i < NCHAN; i++) begin
              if (idx == IDX_W'(i)) begin
                chan_data[i*WIDTH +: WIDTH] <= chan_data[i*WIDTH +: WIDTH] + STEP_V;
              end
            end
            upd_valid  <= 1'b1;
            upd_chan   <= idx;
            step_count <= step_count + CNT_W'(1);
            if (idx == IDX_W'(NCHAN - 1)) begin
              idx   <= '0;
              round <= round + RND_W'(1);
              if (round == RND_W'(REPEATS - 1)) state <= FINISH;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer across three parameter sets.
module tb_stim_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start_a, hold_a, start_b, hold_b, start_c, hold_c;

  logic [15:0] data_a;
  logic        upd_a, busy_a, done_a;
  logic [0:0]  uchan_a;
  logic [3:0]  steps_a;

  logic [23:0] data_b;
  logic        upd_b, busy_b, done_b;
  logic [1:0]  uchan_b;
  logic [2:0]  steps_b;

  logic [3:0]  data_c;
  logic        upd_c, busy_c, done_c;
  logic [0:0]  uchan_c;
  logic [2:0]  steps_c;

  stim_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .hold(hold_a),
    .chan_data(data_a), .upd_valid(upd_a), .upd_chan(uchan_a),
    .step_count(steps_a), .busy(busy_a), .done(done_a)
  );

  stim_sequencer #(
    .NCHAN(3), .WIDTH(8), .PERIOD(1), .REPEATS(2), .STEP(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .hold(hold_b),
    .chan_data(data_b), .upd_valid(upd_b), .upd_chan(uchan_b),
    .step_count(steps_b), .busy(busy_b), .done(done_b)
  );

  stim_sequencer #(
    .NCHAN(1), .WIDTH(4), .PERIOD(2), .REPEATS(6), .STEP(3)
  ) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .hold(hold_c),
    .chan_data(data_c), .upd_valid(upd_c), .upd_chan(uchan_c),
    .step_count(steps_c), .busy(busy_c), .done(done_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int edge_no;
    int ch;
    int val;
    int steps;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   t0[3];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int inst, input bit d, input int e, input int ch,
                      input int val, input int st);
    exp_t x;
    x = '{d, e, ch, val, st};
    case (inst)
      0: qa.push_back(x);
      1: qb.push_back(x);
      default: qc.push_back(x);
    endcase
  endtask

  // Expected events of one run: edges shift by hold_len once at or past hold_at.
  task automatic expect_run(input int inst, input int nch, input int per, input int rep,
                            input int step, input int w, input int off,
                            input int hold_at, input int hold_len);
    int e;
    for (int k = 1; k <= nch * rep; k++) begin
      e = per * k;
      if (hold_len > 0 && e >= hold_at) e += hold_len;
      push(inst, 1'b0, off + e, (k - 1) % nch, (((k - 1) / nch + 1) * step) % (1 << w), k);
    end
    push(inst, 1'b1, off + e + 1, 0, 0, nch * rep);
  endtask

  task automatic observe(input int inst, input bit v, input bit d, input int uchan,
                         input logic [31:0] data, input int w, input int steps,
                         input bit busy);
    exp_t e;
    bit   have;
    int   rel;
    if (!v && !d) return;
    rel  = cyc - t0[inst];
    have = 1'b0;
    case (inst)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event_%0d: got upd=%0d done=%0d at edge %0d, expected none",
               inst, v, d, rel);
      return;
    end
    chk($sformatf("kind_%0d", inst), int'(d), int'(e.is_done));
    chk($sformatf("edge_%0d", inst), rel, e.edge_no);
    chk($sformatf("step_count_%0d", inst), steps, e.steps);
    if (e.is_done) begin
      chk($sformatf("busy_at_done_%0d", inst), int'(busy), 0);
    end else begin
      chk($sformatf("upd_chan_%0d", inst), uchan, e.ch);
      chk($sformatf("chan_value_%0d", inst),
          int'((data >> (e.ch * w)) & ((32'd1 << w) - 32'd1)), e.val);
    end
  endtask

  always @(negedge clk) begin
    observe(0, upd_a, done_a, int'(uchan_a), 32'(data_a), 8, int'(steps_a), busy_a);
    observe(1, upd_b, done_b, int'(uchan_b), 32'(data_b), 8, int'(steps_b), busy_b);
    observe(2, upd_c, done_c, int'(uchan_c), 32'(data_c), 4, int'(steps_c), busy_c);
  end

  task automatic set_start(input int inst, input logic val);
    case (inst)
      0: start_a = val;
      1: start_b = val;
      default: start_c = val;
    endcase
  endtask

  task automatic start_run(input int inst, input bit keep);
    @(negedge clk);
    set_start(inst, 1'b1);
    @(negedge clk);
    t0[inst] = cyc;
    if (!keep) set_start(inst, 1'b0);
  endtask

  task automatic run_basic_a(input string tag);
    start_run(0, 1'b0);
    chk({tag, "_busy_start"}, int'(busy_a), 1);
    chk({tag, "_data_start"}, int'(data_a), 0);
    expect_run(0, 2, 10, 5, 1, 8, 0, 0, 0);
    repeat (105) @(negedge clk);
    chk({tag, "_drain"}, qa.size(), 0);
    chk({tag, "_final_data"}, int'(data_a), 'h0505);
    chk({tag, "_busy_end"}, int'(busy_a), 0);
  endtask

  initial begin
    int rel;
    reset = 1'b1;
    {start_a, hold_a, start_b, hold_b, start_c, hold_c} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_data_a", int'(data_a), 0);
    chk("reset_ctrl_a", int'({upd_a, busy_a, done_a, steps_a}), 0);
    chk("reset_all_b", int'({data_b, upd_b, busy_b, done_b}), 0);
    chk("reset_all_c", int'({data_c, upd_c, busy_c, done_c, steps_c}), 0);

    run_basic_a("basic");

    start_run(1, 1'b0);
    expect_run(1, 3, 1, 2, 1, 8, 0, 0, 0);
    repeat (12) @(negedge clk);
    chk("drain_b", qb.size(), 0);
    chk("final_data_b", int'(data_b), 'h020202);

    start_run(2, 1'b0);
    expect_run(2, 1, 2, 6, 3, 4, 0, 0, 0);
    repeat (20) @(negedge clk);
    chk("drain_c", qc.size(), 0);
    chk("final_data_c", int'(data_c), 2);

    // Hold sampled high on edges 15..21 of the run.
    start_run(0, 1'b0);
    expect_run(0, 2, 10, 5, 1, 8, 0, 15, 7);
    repeat (112) begin
      @(negedge clk);
      rel = cyc - t0[0];
      hold_a = (rel >= 14 && rel <= 20);
    end
    hold_a = 1'b0;
    chk("hold_drain", qa.size(), 0);

    // Mid-run async reset, with ignored start pulses beforehand.
    start_run(0, 1'b0);
    for (int k = 1; k <= 3; k++) push(0, 1'b0, 10 * k, (k - 1) % 2, (k - 1) / 2 + 1, k);
    repeat (35) begin
      @(negedge clk);
      rel = cyc - t0[0];
      start_a = (rel == 12 || rel == 22);
    end
    start_a = 1'b0;
    chk("pre_reset_steps", int'(steps_a), 3);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_data", int'(data_a), 0);
    chk("async_reset_busy", int'(busy_a), 0);
    chk("async_reset_steps", int'(steps_a), 0);
    chk("reset_drain", qa.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    run_basic_a("after_reset");

    // Back-to-back runs with start held through done.
    start_run(0, 1'b1);
    expect_run(0, 2, 10, 5, 1, 8, 0, 0, 0);
    expect_run(0, 2, 10, 5, 1, 8, 102, 0, 0);
    repeat (215) begin
      @(negedge clk);
      rel = cyc - t0[0];
      if (rel == 102) begin
        chk("b2b_busy_restart", int'(busy_a), 1);
        chk("b2b_data_restart", int'(data_a), 0);
        start_a = 1'b0;
      end
    end
    chk("b2b_drain", qa.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
